// File: rtl/div_issue_queue_pkg.sv
// Shared definitions for the divider issue queue: FSM state encoding and the
// quotient returned for a divide-by-zero request.
package div_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssue  = 3'd1,
        StSettle = 3'd2,
        StWait   = 3'd3,
        StResp   = 3'd4
    } div_state_e;

    // All ones at the widest supported operand size; users slice [N-1:0].
    localparam int unsigned MaxN = 64;
    localparam logic [MaxN-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_issue_queue_if.sv
// Request, divider and response signal bundle for div_issue_queue.
// slave is the queue's view; master is the surrounding environment's view.
interface div_issue_queue_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_dividend;
    logic [N-1:0]    in_divisor;

    logic            div_valid;
    logic [N-1:0]    div_dividend;
    logic [N-1:0]    div_divisor;
    logic            div_ready;
    logic [N-1:0]    div_quotient;
    logic [N-1:0]    div_remainder;

    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_quotient;
    logic [N-1:0]    out_remainder;
    logic            out_dbz;

    logic [CntW-1:0] fifo_count;

    modport slave (
        input  in_valid, in_dividend, in_divisor,
        output in_ready,
        output div_valid, div_dividend, div_divisor,
        input  div_ready, div_quotient, div_remainder,
        output out_valid, out_quotient, out_remainder, out_dbz,
        input  out_ready,
        output fifo_count
    );

    modport master (
        output in_valid, in_dividend, in_divisor,
        input  in_ready,
        input  div_valid, div_dividend, div_divisor,
        output div_ready, div_quotient, div_remainder,
        input  out_valid, out_quotient, out_remainder, out_dbz,
        output out_ready,
        input  fifo_count
    );

endinterface

// File: rtl/div_issue_queue_fifo.sv
// Synchronous request FIFO for the divider issue queue. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module div_req_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         din,
    output logic [Width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/div_issue_queue.sv
// Operand staging in front of a sequential unsigned divider: queues requests,
// issues one at a time, answers divide-by-zero locally and returns results in order.
module div_issue_queue
    import div_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    div_issue_queue_if.slave bus
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*N-1:0]  fifo_din, fifo_dout;
    logic [CntW-1:0] fifo_count;
    logic [N-1:0]    head_dividend, head_divisor;

    div_state_e      state_q, state_d;
    logic [N-1:0]    op_dividend_q, op_dividend_d;
    logic [N-1:0]    op_divisor_q, op_divisor_d;
    logic [N-1:0]    res_quotient_q, res_quotient_d;
    logic [N-1:0]    res_remainder_q, res_remainder_d;
    logic            res_dbz_q, res_dbz_d;
    logic            div_valid, out_valid;

    assign fifo_push = bus.in_valid & ~fifo_full;
    assign fifo_din  = {bus.in_dividend, bus.in_divisor};
    assign {head_dividend, head_divisor} = fifo_dout;

    div_req_fifo #(
        .Width (2 * N),
        .Depth (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d         = state_q;
        op_dividend_d   = op_dividend_q;
        op_divisor_d    = op_divisor_q;
        res_quotient_d  = res_quotient_q;
        res_remainder_d = res_remainder_q;
        res_dbz_d       = res_dbz_q;
        fifo_pop        = 1'b0;
        div_valid       = 1'b0;
        out_valid       = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    op_dividend_d = head_dividend;
                    op_divisor_d  = head_divisor;
                    if (head_divisor == '0) begin
                        res_quotient_d  = DBZ_QUOTIENT[N-1:0];
                        res_remainder_d = head_dividend;
                        res_dbz_d       = 1'b1;
                        state_d         = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                div_valid = 1'b1;
                state_d   = StSettle;
            end
            // div_ready may still reflect the previous op here, so it is not sampled.
            StSettle: state_d = StWait;
            StWait: begin
                if (bus.div_ready) begin
                    res_quotient_d  = bus.div_quotient;
                    res_remainder_d = bus.div_remainder;
                    res_dbz_d       = 1'b0;
                    state_d         = StResp;
                end
            end
            StResp: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= StIdle;
            op_dividend_q   <= '0;
            op_divisor_q    <= '0;
            res_quotient_q  <= '0;
            res_remainder_q <= '0;
            res_dbz_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_dividend_q   <= op_dividend_d;
            op_divisor_q    <= op_divisor_d;
            res_quotient_q  <= res_quotient_d;
            res_remainder_q <= res_remainder_d;
            res_dbz_q       <= res_dbz_d;
        end
    end

    // Result fields read as zero until a response is actually presented.
    assign bus.in_ready      = ~fifo_full;
    assign bus.div_valid     = div_valid;
    assign bus.div_dividend  = op_dividend_q;
    assign bus.div_divisor   = op_divisor_q;
    assign bus.out_valid     = out_valid;
    assign bus.out_quotient  = out_valid ? res_quotient_q : '0;
    assign bus.out_remainder = out_valid ? res_remainder_q : '0;
    assign bus.out_dbz       = out_valid & res_dbz_q;
    assign bus.fifo_count    = fifo_count;

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue with a behavioural multi-cycle divider whose
// done flag stays high (stale) for one cycle after each new issue.
module tb_div_issue_queue;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    div_issue_queue_if #(.N(8), .DEPTH(4)) bus ();

    div_issue_queue #(
        .N     (8),
        .DEPTH (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_issue  = 0;
    int pulse_viol = 0;
    int div_cnt;
    logic dv_prev;
    logic [7:0] dv_a, dv_b;

    // Divider model: 5-cycle latency, ready drops one cycle after accepting.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt           <= 0;
            bus.div_ready     <= 1'b0;
            bus.div_quotient  <= '0;
            bus.div_remainder <= '0;
            dv_a              <= '0;
            dv_b              <= '0;
        end else if (bus.div_valid) begin
            dv_a    <= bus.div_dividend;
            dv_b    <= bus.div_divisor;
            div_cnt <= 5;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) begin
                bus.div_ready     <= 1'b1;
                bus.div_quotient  <= (dv_b == 0) ? 8'hee : dv_a / dv_b;
                bus.div_remainder <= (dv_b == 0) ? 8'hee : dv_a % dv_b;
            end else begin
                bus.div_ready <= 1'b0;
            end
        end
    end

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            dv_prev <= 1'b0;
        end else begin
            dv_prev <= bus.div_valid;
            if (bus.div_valid) begin
                n_issue <= n_issue + 1;
                if (dv_prev) pulse_viol <= pulse_viol + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        tick();
        bus.in_valid    = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!bus.out_valid && i < 100) begin
            tick();
            i++;
        end
        check_eq({tag, "_valid"}, bus.out_valid, 1);
    endtask

    task automatic wait_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                               input logic dbz);
        wait_valid(tag);
        check_eq({tag, "_q"}, bus.out_quotient, q);
        check_eq({tag, "_r"}, bus.out_remainder, r);
        check_eq({tag, "_dbz"}, bus.out_dbz, dbz);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        int n0;
        RST             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_div_valid", bus.div_valid, 0);
        check_eq("rst_count", bus.fifo_count, 0);
        check_eq("rst_out_q", bus.out_quotient, 0);
        check_eq("rst_out_dbz", bus.out_dbz, 0);
        RST = 1'b0;
        tick();

        // Basic issue: 100/7
        n0 = n_issue;
        push(8'd100, 8'd7);
        tick();
        check_eq("t1_div_valid", bus.div_valid, 1);
        check_eq("t1_div_a", bus.div_dividend, 100);
        check_eq("t1_div_b", bus.div_divisor, 7);
        wait_result("t1", 8'd14, 8'd2, 1'b0);
        check_eq("t1_issue_cnt", n_issue - n0, 1);

        // Divide-by-zero resolved locally, two cycles after push
        n0 = n_issue;
        push(8'd5, 8'd0);
        check_eq("t2_early", bus.out_valid, 0);
        tick();
        check_eq("t2_valid", bus.out_valid, 1);
        check_eq("t2_q", bus.out_quotient, 255);
        check_eq("t2_r", bus.out_remainder, 5);
        check_eq("t2_dbz", bus.out_dbz, 1);
        tick();
        check_eq("t2_done", bus.out_valid, 0);
        check_eq("t2_no_issue", n_issue - n0, 0);

        // Stall in RESP while filling the FIFO to full
        bus.out_ready = 1'b0;
        push(8'd77, 8'd10);
        wait_valid("t4a");
        push(8'd255, 8'd16);
        push(8'd9, 8'd3);
        push(8'd0, 8'd5);
        push(8'd200, 8'd200);
        check_eq("t3_in_ready", bus.in_ready, 0);
        check_eq("t3_count", bus.fifo_count, 4);
        n0 = n_issue;
        for (int i = 0; i < 10; i++) begin
            check_eq("t4_hold_valid", bus.out_valid, 1);
            check_eq("t4_hold_q", bus.out_quotient, 7);
            check_eq("t4_hold_r", bus.out_remainder, 7);
            tick();
        end
        check_eq("t4_hold_count", bus.fifo_count, 4);
        check_eq("t4_no_issue", n_issue - n0, 0);
        bus.out_ready = 1'b1;
        wait_result("t4", 8'd7, 8'd7, 1'b0);
        wait_result("t3_a", 8'd15, 8'd15, 1'b0);
        wait_result("t3_b", 8'd3, 8'd0, 1'b0);
        wait_result("t3_c", 8'd0, 8'd0, 1'b0);
        wait_result("t3_d", 8'd1, 8'd0, 1'b0);
        check_eq("t3_drained", bus.fifo_count, 0);
        check_eq("t3_in_ready_back", bus.in_ready, 1);

        // Simultaneous push and pop at count 2
        bus.out_ready = 1'b0;
        push(8'd60, 8'd7);
        wait_valid("t6a");
        push(8'd30, 8'd4);
        push(8'd17, 8'd5);
        check_eq("t6_count2", bus.fifo_count, 2);
        bus.out_ready = 1'b1;
        check_eq("t6a_q", bus.out_quotient, 8);
        check_eq("t6a_r", bus.out_remainder, 4);
        tick();
        check_eq("t6_pre", bus.fifo_count, 2);
        push(8'd45, 8'd6);
        check_eq("t6_same", bus.fifo_count, 2);
        wait_result("t6_b", 8'd7, 8'd2, 1'b0);
        wait_result("t6_c", 8'd3, 8'd2, 1'b0);
        wait_result("t6_d", 8'd7, 8'd3, 1'b0);
        check_eq("t6_drained", bus.fifo_count, 0);

        // Reset while waiting on the divider
        n0 = n_issue;
        push(8'd200, 8'd9);
        push(8'd1, 8'd1);
        push(8'd2, 8'd1);
        check_eq("t5_issued", n_issue - n0, 1);
        check_eq("t5_count_pre", bus.fifo_count, 2);
        tick();
        RST = 1'b1;
        tick();
        check_eq("t5_count", bus.fifo_count, 0);
        check_eq("t5_out_valid", bus.out_valid, 0);
        check_eq("t5_div_valid", bus.div_valid, 0);
        check_eq("t5_in_ready", bus.in_ready, 1);
        RST = 1'b0;
        tick();
        push(8'd50, 8'd8);
        wait_result("t5_post", 8'd6, 8'd2, 1'b0);
        check_eq("t5_empty", bus.fifo_count, 0);

        check_eq("dv_pulse_width", pulse_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
